ps2_keycode_rx: RTL and testbench
=================================

Name: ps2_keycode_rx

Overview:
PS/2 keyboard receiver that drives the 8-bit keycode input port read by the Nios II game controller. It samples the keyboard's ps2_clk/ps2_data lines and deframes 11-bit frames. It then decodes make, break (F0) and extended (E0) sequences and holds the currently pressed key's code on keycode, or 0x00 when no key is held. Software polls keycode to trigger the flap.

Parameters:
FILTER_LEN, 8, consecutive clk cycles the synchronized ps2_clk must stay stable before its filtered level changes.
TIMEOUT_CYCLES, 50000, clk cycles without a filtered ps2_clk falling edge mid-frame before the frame is abandoned (1 ms at 50 MHz).

Ports:
clk  input  1  system clock, 50 MHz
reset_n  input  1  reset, asynchronous, active-low
ps2_clk  input  1  keyboard clock line, asynchronous to clk
ps2_data  input  1  keyboard data line, asynchronous to clk
keycode  output  8  code of the currently held key; 0x00 when none; feeds the keycode PIO in_port
extended  output  1  1 when the held key was prefixed by E0
key_valid  output  1  one-cycle pulse when keycode/extended load a new make code
frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error

Behaviour:
- Reset: keycode=0x00, extended=0, key_valid=0, frame_err=0; frame FSM IDLE; prefix flags clear; filtered clk=1; synchronizers=1.
- Input conditioning: ps2_clk and ps2_data each pass a 2-FF synchronizer.
- Glitch filter: filtered clk changes only after the synchronized clk differs from it for FILTER_LEN consecutive cycles.
- Sampling: a falling edge of filtered clk (1->0) samples synchronized data.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on edge with data=0 (start bit) go to DATA with bit count 0. Edge with data=1 is ignored.
  - DATA: each edge stores data into bit[count], LSB first. After the 8th bit go to PARITY.
  - PARITY: the edge captures the parity bit, then go to STOP.
  - STOP: the edge checks the frame, then always returns to IDLE.
    - Stop=1 and odd parity over data+parity: byte_strobe pulses for 1 cycle with the byte.
    - Otherwise: frame_err pulses and no byte is produced.
- Timeout: a counter clears on every edge and in IDLE.
  - In DATA/PARITY/STOP, when it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse frame_err, discard partial byte.
- Decoder (prefix flags ext, brk), acting on byte_strobe:
  - E0 sets ext.
  - F0 sets brk.
  - Any other byte with brk=0: keycode<=byte, extended<=ext, key_valid pulses, flags clear. This applies to repeats of the same code too (typematic).
  - Any other byte with brk=1: if byte==keycode and ext==extended, then keycode<=0x00 and extended<=0. Otherwise outputs are unchanged (release of a non-held key). Flags clear either way.
  - E0 and F0 are never loaded into keycode.
- Any frame_err clears ext and brk; keycode/extended hold.
- Latency: byte_strobe is asserted the cycle after the stop-bit edge. keycode/extended/key_valid update the following cycle, 2 clk after the stop-bit edge.
- Simultaneous timeout and edge in the same cycle: the edge wins and the timeout is not flagged.
- Asynchronous reset mid-frame: all state returns to reset values immediately. Outputs are 0x00 until a complete new make code arrives.

Test Plan:
1. Reset, then frame for 0x1D (data LSB first, parity 1, stop 1) -> keycode=0x1D, extended=0, key_valid high exactly 1 cycle, frame_err never high.
2. After test 1, frames F0 then 1D -> keycode=0x00 after the second frame; no key_valid pulse.
3. Frames E0, 75 -> keycode=0x75, extended=1. Then E0, F0, 75 -> keycode=0x00, extended=0. Then 1D, F0, 29 -> keycode stays 0x1D.
4. Frame 0x29 with wrong parity -> frame_err 1 pulse, keycode unchanged. Frame with stop=0 -> same.
5. Send start + 4 data bits, stop toggling for TIMEOUT_CYCLES -> frame_err 1 pulse, FSM IDLE. Next valid 0x29 frame -> keycode=0x29.
6. ps2_clk low glitches of FILTER_LEN-1 cycles during idle and mid-frame -> no sample taken, decoded byte correct. Assert reset_n low mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronizes and glitch-filters the PS/2 lines, deframes
// 11-bit frames and turns make/break/E0 sequences into the currently held keycode.
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       extended,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           fall;

  state_t         state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           par_q, par_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           strobe_q, strobe_d;
  logic [7:0]     byte_q, byte_d;
  logic           ferr_q, ferr_d;

  logic [7:0]     keycode_q, keycode_d;
  logic           extended_q, extended_d;
  logic           kv_q, kv_d;
  logic           ext_q, ext_d;
  logic           brk_q, brk_d;

  // Filtered clock flips on the FILTER_LEN-th consecutive cycle of disagreement;
  // the falling edge is reported in that same cycle so data is sampled alongside it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = ~filt_q;
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end
  end

  // A sampling edge always takes priority over an expiring timeout.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    tcnt_d   = tcnt_q + TCW'(1);
    strobe_d = 1'b0;
    byte_d   = byte_q;
    ferr_d   = 1'b0;
    if (fall) begin
      tcnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d  = S_DATA;
            bitcnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shreg_d[bitcnt_q] = dat_s2_q;
          bitcnt_d          = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_s2_q && (^{shreg_q, par_q})) begin
            strobe_d = 1'b1;
            byte_d   = shreg_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_IDLE) begin
      tcnt_d = '0;
    end else if (tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_IDLE;
      tcnt_d  = '0;
      shreg_d = '0;
      ferr_d  = 1'b1;
    end
  end

  // A release only clears the output when it names exactly the held key.
  always_comb begin
    keycode_d  = keycode_q;
    extended_d = extended_q;
    kv_d       = 1'b0;
    ext_d      = ext_q;
    brk_d      = brk_q;
    if (strobe_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (!brk_q) begin
          keycode_d  = byte_q;
          extended_d = ext_q;
          kv_d       = 1'b1;
        end else if ((byte_q == keycode_q) && (ext_q == extended_q)) begin
          keycode_d  = 8'h00;
          extended_d = 1'b0;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end else if (ferr_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tcnt_q     <= '0;
      strobe_q   <= 1'b0;
      byte_q     <= '0;
      ferr_q     <= 1'b0;
      keycode_q  <= 8'h00;
      extended_q <= 1'b0;
      kv_q       <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tcnt_q     <= tcnt_d;
      strobe_q   <= strobe_d;
      byte_q     <= byte_d;
      ferr_q     <= ferr_d;
      keycode_q  <= keycode_d;
      extended_q <= extended_d;
      kv_q       <= kv_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
    end
  end

  assign keycode   = keycode_q;
  assign extended  = extended_q;
  assign key_valid = kv_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: directed and randomized PS/2 frames checked against a
// byte-level model of the make/break/E0 rules.
module tb_ps2_keycode_rx;

  localparam int FL = 8;
  localparam int TO = 3000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       extended;
  logic       key_valid;
  logic       frame_err;

  ps2_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .keycode  (keycode),
    .extended (extended),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int half   = 30;

  // Pulse monitor
  int   kv_hi = 0, kv_rise = 0, fe_cnt = 0;
  logic kv_prev = 1'b0;
  always @(posedge clk) begin
    if (key_valid) kv_hi++;
    if (key_valid && !kv_prev) kv_rise++;
    kv_prev = key_valid;
    if (frame_err) fe_cnt++;
  end

  // Reference model at byte level
  logic [7:0] mk   = 8'h00;
  logic       mext = 1'b0;
  logic       mfx  = 1'b0;
  logic       mbrk = 1'b0;
  int         exp_kv = 0, exp_fe = 0;

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) mfx = 1'b1;
    else if (b == 8'hF0) mbrk = 1'b1;
    else begin
      if (!mbrk) begin
        mk = b; mext = mfx; exp_kv++;
      end else if (b == mk && mfx == mext) begin
        mk = 8'h00; mext = 1'b0;
      end
      mfx = 1'b0; mbrk = 1'b0;
    end
  endfunction

  function automatic void model_err();
    exp_fe++; mfx = 1'b0; mbrk = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".keycode"}, {24'd0, keycode}, {24'd0, mk});
    chk({tag, ".extended"}, {31'd0, extended}, {31'd0, mext});
    chk({tag, ".kv_pulses"}, kv_rise, exp_kv);
    chk({tag, ".kv_cycles"}, kv_hi, exp_kv);
    chk({tag, ".frame_err"}, fe_cnt, exp_fe);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_glitch();
    ps2_clk = 1'b0;
    wait_cyc(FL - 1);
    ps2_clk = 1'b1;
  endtask

  // Drive the first n bits of a frame; gl selects a bit whose high phase gets a glitch.
  task automatic drive_bits(input logic [10:0] bits, input int n, input int gl);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cyc(half / 2);
      ps2_clk = 1'b0;
      wait_cyc(half);
      ps2_clk = 1'b1;
      if (i == gl) begin
        wait_cyc(14);
        ps2_glitch();
        wait_cyc(14);
      end
      wait_cyc(half / 2);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int gl);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    drive_bits(bits, 11, gl);
    ps2_data = 1'b1;
    wait_cyc(40);
    if (bad_par || bad_stop) model_err();
    else model_byte(b);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, -1);
  endtask

  initial begin
    logic [7:0] rb;
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    chk("reset.keycode", {24'd0, keycode}, 32'h0);
    chk("reset.extended", {31'd0, extended}, 32'h0);
    chk("reset.key_valid", {31'd0, key_valid}, 32'h0);
    chk("reset.frame_err", {31'd0, frame_err}, 32'h0);
    reset_n = 1'b1;
    wait_cyc(20);

    send(8'h1D);                   check_state("t1_make");
    send(8'hF0); send(8'h1D);      check_state("t2_break");
    send(8'hE0); send(8'h75);      check_state("t3_ext_make");
    send(8'hE0); send(8'hF0); send(8'h75); check_state("t3_ext_break");
    send(8'h1D); send(8'hF0); send(8'h29); check_state("t3_other_release");
    send(8'hE0); send(8'hF0); send(8'h1D); check_state("t3_ext_mismatch");

    send_frame(8'h29, 1'b1, 1'b0, -1); check_state("t4_parity");
    send(8'hF0);
    send_frame(8'h29, 1'b0, 1'b1, -1); check_state("t4_stop");
    send(8'h1D);                       check_state("t4_flags_cleared");

    drive_bits(11'b110_0101_1010, 5, -1);
    ps2_data = 1'b1;
    wait_cyc(TO + 100);
    model_err();                       check_state("t5_timeout");
    send(8'h29);                       check_state("t5_recover");

    wait_cyc(20);
    ps2_glitch();
    wait_cyc(30);
    ps2_glitch();
    wait_cyc(30);                      check_state("t6_idle_glitch");
    send_frame(8'h75, 1'b0, 1'b0, 3);  check_state("t6_mid_glitch");
    send_frame(8'hF0, 1'b0, 1'b0, 9);
    send_frame(8'h75, 1'b0, 1'b0, 0);  check_state("t6_glitch_release");

    send(8'h5A);
    drive_bits(11'b110_0110_1100, 4, -1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst.keycode", {24'd0, keycode}, 32'h0);
    chk("t6_rst.extended", {31'd0, extended}, 32'h0);
    chk("t6_rst.key_valid", {31'd0, key_valid}, 32'h0);
    chk("t6_rst.frame_err", {31'd0, frame_err}, 32'h0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    reset_n = 1'b1;
    mk = 8'h00; mext = 1'b0; mfx = 1'b0; mbrk = 1'b0;
    wait_cyc(50);                      check_state("t6_after_reset");
    send(8'h1D);                       check_state("t6_make_after_reset");

    for (int n = 0; n < 24; n++) begin
      half = int'($urandom_range(20, 40));
      case ($urandom_range(0, 6))
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        2: rb = mk;
        3: rb = 8'h1D;
        4: rb = 8'h75;
        default: rb = 8'($urandom_range(1, 8'hDF));
      endcase
      send_frame(rb, ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
      check_state("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
